async_fifo_rd_stream: RTL and testbench
=======================================

// Module: async_fifo_rd_stream
// PURPOSE
//  Read-side consumer for the dual-clock FIFO, in the FIFO read clock domain.
//  Drives fifo_rd_en from the FIFO's registered empty flag.
//  Captures fifo_rd_data after the RAM read latency.
//  Presents words as a valid/ready stream through an internal skid buffer, so
//  downstream backpressure never loses a word or over-reads the FIFO.
// PARAMETERS
//  DATA_WIDTH  16  FIFO word width
//  BUF_DEPTH   4   skid-buffer entries; power of two, >=2
//  RD_LAT      1   cycles from fifo_rd_en to valid fifo_rd_data; 1 or 2
//  EMPTY_LAG   1   1: fifo_empty lags the FIFO pointer by one cycle, so no
//                  back-to-back reads; 0: back-to-back reads allowed
//  CNT_WIDTH   32  width of rd_word_cnt
// PORTS
//  fifo_rd_clk   in   1           clock, the FIFO read clock
//  rst           in   1           synchronous reset, active-high
//  fifo_empty    in   1           registered empty flag from the FIFO
//  fifo_rd_en    out  1           read request to the FIFO
//  fifo_rd_data  in   DATA_WIDTH  FIFO read data, valid RD_LAT cycles after fifo_rd_en
//  flush         in   1           synchronous discard of buffered and in-flight words
//  m_data        out  DATA_WIDTH  stream data
//  m_valid       out  1           stream valid
//  m_ready       in   1           stream ready
//  buf_count     out  clog2(BUF_DEPTH)+1  skid-buffer occupancy
//  rd_word_cnt   out  CNT_WIDTH   words delivered on the stream (valid&&ready); wraps
// BEHAVIOUR
//  Reset (rst=1 at a clock edge): fifo_rd_en=0, m_valid=0, m_data=0, buf_count=0,
//   rd_word_cnt=0; in-flight pipe and buffer pointers cleared.
//   A reset asserted mid-burst discards all buffered and in-flight words.
//  Read issue: fifo_rd_en = !fifo_empty && !flush && !rst
//   && (buf_count + inflight < BUF_DEPTH) && !(EMPTY_LAG && rd_en_q).
//   - Combinational from registered state plus fifo_empty only; no m_ready path.
//   - inflight = number of reads issued but whose data is not yet captured (0..RD_LAT).
//  Capture: an RD_LAT-deep valid shift pipe tracks issued reads. When a valid
//   bit exits the pipe, fifo_rd_data is written to the buffer tail that cycle.
//  Credit check: the credit check guarantees the buffer never overflows.
//   An overflow write is an assertion failure.
//  Stream:
//   - m_valid = (buf_count != 0).
//   - m_data = head entry, registered and stable while m_valid && !m_ready.
//   - Handshake occurs on m_valid && m_ready: head pointer advances, rd_word_cnt++.
//  Latency: FIFO non-empty seen -> m_valid high = RD_LAT+1 cycles.
//  Simultaneous capture and handshake in one cycle: buf_count unchanged, both
//   pointers advance.
//   - Capture into an empty buffer while m_ready=1: the word appears next cycle;
//     there is no same-cycle bypass.
//  Pointers: log2(BUF_DEPTH)-bit wrap naturally. buf_count is held in a separate
//   counter of width clog2+1, so full (BUF_DEPTH) and empty (0) are distinct.
//  Flush (1 cycle):
//   - Next cycle: buf_count=0, m_valid=0, in-flight pipe cleared.
//   - Data arriving from reads issued before the flush is dropped.
//   - rd_word_cnt is kept. No read is issued in the flush cycle.
//  fifo_empty glitch tolerance (EMPTY_LAG=1): a read is never issued in the cycle
//   after a read. A stale fifo_empty=0 therefore never causes a read of an empty FIFO.
// TESTING
//  T1 reset: rst=1 for 3 cycles with fifo_empty=0
//     -> fifo_rd_en=0, m_valid=0, buf_count=0, rd_word_cnt=0 throughout.
//  T2 single word: FIFO holds 0xA5A5, m_ready=1 -> fifo_rd_en pulses once;
//     m_valid high 2 cycles later (RD_LAT=1) with m_data=0xA5A5;
//     rd_word_cnt=1; buf_count returns to 0.
//  T3 burst, EMPTY_LAG=1: 8 words 0..7, m_ready=1
//     -> fifo_rd_en never high in two consecutive cycles;
//     stream delivers 0..7 in order; rd_word_cnt=8.
//  T4 backpressure: m_ready=0, 10 words queued
//     -> reads stop when buf_count+inflight=4; buf_count=4; m_data=0 is held stable;
//     m_ready=1 then drains 0..9 in order, no loss, no duplicates.
//  T5 flush mid-flight: buf_count=3 plus 1 in-flight read, flush=1 for one cycle
//     -> next cycle m_valid=0, buf_count=0; in-flight word dropped;
//     next FIFO word is the first one delivered.
//  T6 wrap and random: 1000 sequential words, random m_ready (50%), EMPTY_LAG=0/1,
//     RD_LAT=1/2 -> scoreboard exact order; buf_count<=BUF_DEPTH always;
//     rd_word_cnt=1000.

Source files
------------

// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
//   Read-side consumer for a dual-clock FIFO, running in the FIFO read clock
//   domain. It issues reads from the FIFO's registered empty flag, captures the
//   returned word after the RAM read latency, and presents the words as a
//   valid/ready stream through a small skid buffer. Reads are credit-limited
//   against buffer space, so backpressure never drops a word or over-reads.
//
// Ports
//   fifo_rd_clk   in   clock (FIFO read clock)
//   rst           in   synchronous reset, active-high
//   fifo_empty    in   registered empty flag from the FIFO
//   fifo_rd_en    out  read request to the FIFO
//   fifo_rd_data  in   FIFO read data, valid RD_LAT cycles after fifo_rd_en
//   flush         in   discard buffered and in-flight words (one cycle)
//   m_data        out  stream data (head of the skid buffer, registered)
//   m_valid       out  stream valid
//   m_ready       in   stream ready
//   buf_count     out  skid-buffer occupancy, 0..BUF_DEPTH
//   rd_word_cnt   out  words delivered on the stream, wraps
module async_fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4,
  parameter int RD_LAT     = 1,
  parameter int EMPTY_LAG  = 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                         fifo_rd_clk,
  input  logic                         rst,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [$clog2(BUF_DEPTH):0]   buf_count,
  output logic [CNT_WIDTH-1:0]         rd_word_cnt
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]   FULL_C  = CW'(BUF_DEPTH);
  localparam logic [CW+1:0]   DEPTH_C = (CW+2)'(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_reg [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]         count_reg, count_next, count_after_pop;
  logic [RD_LAT-1:0]     pipe_reg, pipe_next;
  logic                  rd_en_q_reg;
  logic [DATA_WIDTH-1:0] m_data_reg, m_data_next;
  logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
  logic [CW+1:0]         inflight;
  logic                  rd_en;
  logic                  capture;
  logic                  pop;

  // Reads issued whose data has not yet been written into the buffer.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + (CW+2)'(pipe_reg[i]);
    end
  end

  // Credit check counts the word exiting the pipe this cycle as in flight but
  // takes no credit for a same-cycle pop, keeping m_ready out of this path.
  assign rd_en = !fifo_empty && !flush && !rst
               && (({2'b00, count_reg} + inflight) < DEPTH_C)
               && !((EMPTY_LAG != 0) && rd_en_q_reg);

  assign fifo_rd_en = rd_en;

  // Valid shift pipe tracking issued reads through the RAM latency.
  assign pipe_next[0] = rd_en;
  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
      assign pipe_next[gi] = pipe_reg[gi-1];
    end
  endgenerate

  assign capture = pipe_reg[RD_LAT-1] && !flush;
  assign m_valid = (count_reg != '0);
  assign pop     = m_valid && m_ready;

  always_comb begin
    count_after_pop = count_reg - CW'(pop);
    count_next      = count_after_pop + CW'(capture);
    wr_ptr_next     = wr_ptr_reg + PW'(capture);
    rd_ptr_next     = rd_ptr_reg + PW'(pop);
    cnt_next        = cnt_reg + CNT_WIDTH'(pop);
    m_data_next     = m_data_reg;
    // Pre-load the next head into the output register. A word captured into a
    // buffer that is empty after this cycle's pop is not yet in the array, so
    // it is taken straight from the FIFO data bus.
    if (count_next != '0) begin
      if (capture && (count_after_pop == '0)) begin
        m_data_next = fifo_rd_data;
      end else begin
        m_data_next = mem_reg[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge fifo_rd_clk) begin
    if (capture) begin
      mem_reg[wr_ptr_reg] <= fifo_rd_data;
    end
  end

  always_ff @(posedge fifo_rd_clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      pipe_reg    <= '0;
      rd_en_q_reg <= 1'b0;
      m_data_reg  <= '0;
      cnt_reg     <= '0;
    end else begin
      rd_en_q_reg <= rd_en;
      cnt_reg     <= cnt_next;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        pipe_reg   <= '0;
      end else begin
        wr_ptr_reg <= wr_ptr_next;
        rd_ptr_reg <= rd_ptr_next;
        count_reg  <= count_next;
        pipe_reg   <= pipe_next;
        m_data_reg <= m_data_next;
      end
    end
  end

  // The credit check must make a capture into a full buffer impossible.
  always_ff @(posedge fifo_rd_clk) begin
    if (!rst) begin
      assert (!(capture && !pop && (count_reg == FULL_C)));
    end
  end

  assign m_data      = m_data_reg;
  assign buf_count   = count_reg;
  assign rd_word_cnt = cnt_reg;

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
module tb_async_fifo_rd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, m_ready;
  logic [1:0]  fifo_empty, fifo_rd_en, m_valid;
  logic [15:0] m_data [2];
  logic [2:0]  buf_count [2];
  logic [31:0] rd_word_cnt [2];
  logic [15:0] d1 [2];
  logic [15:0] d2 [2];

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // FIFO model, expected-word scoreboard and delivered-word log per DUT.
  logic [15:0] fifo_mem [2][4096];
  int          fifo_wr [2];
  int          fifo_rd [2];
  int          sz_last [2];
  logic [15:0] exp_mem [2][4096];
  int          exp_wr [2];
  int          exp_rd [2];
  logic [15:0] del_mem [2][4096];
  int          del_n [2];
  int          cnt_m [2];

  logic [1:0]  next_empty = 2'b11;
  logic [15:0] d1_next [2];
  logic [15:0] d2_next [2];
  logic [1:0]  prev_hold = 2'b00;
  logic [1:0]  prev_rd_en = 2'b00;
  logic [15:0] prev_data [2];

  // dut0: RD_LAT=1 with lagging empty; dut1: RD_LAT=2 with exact empty.
  async_fifo_rd_stream #(.DATA_WIDTH(16), .BUF_DEPTH(4), .RD_LAT(1), .EMPTY_LAG(1), .CNT_WIDTH(32)) dut0 (
    .fifo_rd_clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
    .fifo_rd_data(d1[0]), .flush(flush), .m_data(m_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready), .buf_count(buf_count[0]), .rd_word_cnt(rd_word_cnt[0]));

  async_fifo_rd_stream #(.DATA_WIDTH(16), .BUF_DEPTH(4), .RD_LAT(2), .EMPTY_LAG(0), .CNT_WIDTH(32)) dut1 (
    .fifo_rd_clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
    .fifo_rd_data(d2[1]), .flush(flush), .m_data(m_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready), .buf_count(buf_count[1]), .rd_word_cnt(rd_word_cnt[1]));

  // FIFO outputs change just after the clock edge, like registered outputs.
  initial begin
    fifo_empty = 2'b11;
    for (int i = 0; i < 2; i++) begin
      d1[i] = '0; d2[i] = '0; d1_next[i] = '0; d2_next[i] = '0;
      fifo_wr[i] = 0; fifo_rd[i] = 0; sz_last[i] = 0;
      exp_wr[i] = 0; exp_rd[i] = 0; del_n[i] = 0; cnt_m[i] = 0;
    end
    forever begin
      @(posedge clk); #1;
      fifo_empty = next_empty;
      for (int i = 0; i < 2; i++) begin
        d1[i] = d1_next[i];
        d2[i] = d2_next[i];
      end
    end
  end

  // Mid-cycle monitor: stream rules, scoreboard and the FIFO read model.
  initial begin
    forever begin
      bit hs;
      int sz;
      logic [15:0] w;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        hs = m_valid[i] && m_ready;
        if (started) begin
          checks++;
          if (buf_count[i] > 3'd4) begin
            failures++; $display("FAIL buf_count_bound dut%0d: got %0d limit 4", i, buf_count[i]);
          end
          checks++;
          if (m_valid[i] !== (buf_count[i] != 3'd0)) begin
            failures++; $display("FAIL valid_vs_count dut%0d: m_valid=%b buf_count=%0d", i, m_valid[i], buf_count[i]);
          end
          checks++;
          if (rd_word_cnt[i] !== 32'(cnt_m[i])) begin
            failures++; $display("FAIL rd_word_cnt dut%0d: got %0d expected %0d", i, rd_word_cnt[i], cnt_m[i]);
          end
          if (prev_hold[i]) begin
            checks++;
            if (m_valid[i] !== 1'b1 || m_data[i] !== prev_data[i]) begin
              failures++; $display("FAIL hold_stable dut%0d: valid=%b data=%h expected data=%h", i, m_valid[i], m_data[i], prev_data[i]);
            end
          end
          if (rst || flush) begin
            checks++;
            if (fifo_rd_en[i] !== 1'b0) begin
              failures++; $display("FAIL read_in_rst_flush dut%0d: fifo_rd_en=%b expected 0", i, fifo_rd_en[i]);
            end
          end
          if (i == 0 && prev_rd_en[0]) begin
            checks++;
            if (fifo_rd_en[0] !== 1'b0) begin
              failures++; $display("FAIL back_to_back_read dut0: fifo_rd_en=%b expected 0", fifo_rd_en[0]);
            end
          end
          if (hs) begin
            checks++;
            if (exp_rd[i] == exp_wr[i]) begin
              failures++; $display("FAIL unexpected_word dut%0d: got %h expected none", i, m_data[i]);
            end else begin
              if (m_data[i] !== exp_mem[i][exp_rd[i]]) begin
                failures++; $display("FAIL stream_order dut%0d: got %h expected %h", i, m_data[i], exp_mem[i][exp_rd[i]]);
              end
              exp_rd[i]++;
            end
            del_mem[i][del_n[i]] = m_data[i];
            del_n[i]++;
          end
        end
        sz = fifo_wr[i] - fifo_rd[i];
        w  = 16'($urandom);
        if (fifo_rd_en[i] === 1'b1) begin
          if (started) begin
            checks++;
            if (sz == 0) begin
              failures++; $display("FAIL fifo_underflow dut%0d: read with 0 words, expected no read", i);
            end
          end
          if (sz > 0) begin
            w = fifo_mem[i][fifo_rd[i]];
            fifo_rd[i]++;
            exp_mem[i][exp_wr[i]] = w;
            exp_wr[i]++;
            sz--;
          end
        end
        // Reset or flush discards every word read but not yet delivered.
        if (rst || flush) exp_rd[i] = exp_wr[i];
        d2_next[i] = d1[i];
        d1_next[i] = w;
        next_empty[i] = (i == 0) ? (sz_last[i] == 0) : (sz == 0);
        sz_last[i] = sz;
        if (rst) cnt_m[i] = 0;
        else if (hs && started) cnt_m[i]++;
        prev_hold[i]  = m_valid[i] && !m_ready && !rst && !flush;
        prev_data[i]  = m_data[i];
        prev_rd_en[i] = fifo_rd_en[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic push(input int i, input logic [15:0] w);
    fifo_mem[i][fifo_wr[i]] = w;
    fifo_wr[i]++;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      fifo_wr[i] = 0; fifo_rd[i] = 0; exp_wr[i] = 0; exp_rd[i] = 0; del_n[i] = 0;
    end
    tick(3);
    rst = 1'b0;
  endtask

  task automatic wait_cnt(input int i, input int n, input int budget, input string name);
    int k;
    for (k = 0; k < budget; k++) begin
      if (cnt_m[i] >= n) break;
      tick(1);
    end
    checks++;
    if (cnt_m[i] < n) begin
      failures++; $display("FAIL %s_timeout: delivered %0d expected %0d", name, cnt_m[i], n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 16'(16'h1100 + k));
    tick(3);
    started = 1'b1;
    repeat (3) begin
      checks++;
      if (fifo_rd_en[0] !== 1'b0 || m_valid[0] !== 1'b0 || buf_count[0] !== 3'd0 ||
          rd_word_cnt[0] !== 32'd0 || m_data[0] !== 16'h0) begin
        failures++;
        $display("FAIL reset_state: rd_en=%b valid=%b count=%0d cnt=%0d data=%h expected 0 0 0 0 0000",
                 fifo_rd_en[0], m_valid[0], buf_count[0], rd_word_cnt[0], m_data[0]);
      end
      tick(1);
    end
  endtask

  task automatic test_single();
    bit found = 1'b0;
    int n_rd;
    do_reset();
    m_ready = 1'b1;
    push(0, 16'hA5A5);
    for (int k = 0; k < 10 && !found; k++) begin
      tick(1);
      if (fifo_rd_en[0] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL single_read_timeout: got no fifo_rd_en expected one");
      return;
    end
    n_rd = 1;
    tick(1);
    n_rd += int'(fifo_rd_en[0]);
    checks++;
    if (m_valid[0] !== 1'b0) begin
      failures++; $display("FAIL single_early_valid: got %b expected 0", m_valid[0]);
    end
    tick(1);
    n_rd += int'(fifo_rd_en[0]);
    checks++;
    if (m_valid[0] !== 1'b1 || m_data[0] !== 16'hA5A5 || buf_count[0] !== 3'd1) begin
      failures++; $display("FAIL single_word: valid=%b data=%h count=%0d expected 1 a5a5 1", m_valid[0], m_data[0], buf_count[0]);
    end
    tick(1);
    checks++;
    if (m_valid[0] !== 1'b0 || buf_count[0] !== 3'd0 || rd_word_cnt[0] !== 32'd1) begin
      failures++; $display("FAIL single_done: valid=%b count=%0d cnt=%0d expected 0 0 1", m_valid[0], buf_count[0], rd_word_cnt[0]);
    end
    repeat (4) begin
      n_rd += int'(fifo_rd_en[0]);
      tick(1);
    end
    checks++;
    if (n_rd != 1) begin
      failures++; $display("FAIL single_read_pulses: got %0d expected 1", n_rd);
    end
  endtask

  task automatic check_seq(input int i, input int n, input int base, input string name);
    int bad = 0;
    for (int k = 0; k < n; k++) if (del_mem[i][k] !== 16'(base + k)) bad++;
    checks++;
    if (del_n[i] != n || bad != 0) begin
      failures++; $display("FAIL %s: delivered %0d words with %0d out of order, expected %0d in order", name, del_n[i], bad, n);
    end
  endtask

  task automatic test_burst();
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(0, 16'(k));
    wait_cnt(0, 8, 200, "burst");
    check_seq(0, 8, 0, "burst_order");
    checks++;
    if (rd_word_cnt[0] !== 32'd8) begin
      failures++; $display("FAIL burst_count: got %0d expected 8", rd_word_cnt[0]);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 10; k++) push(0, 16'(k));
    tick(20);
    checks++;
    if (buf_count[0] !== 3'd4 || m_valid[0] !== 1'b1 || m_data[0] !== 16'h0 || (fifo_wr[0] - fifo_rd[0]) != 6) begin
      failures++; $display("FAIL backpressure_fill: count=%0d valid=%b data=%h left=%0d expected 4 1 0000 6",
                           buf_count[0], m_valid[0], m_data[0], fifo_wr[0] - fifo_rd[0]);
    end
    tick(5);
    checks++;
    if (m_data[0] !== 16'h0 || buf_count[0] !== 3'd4) begin
      failures++; $display("FAIL backpressure_hold: data=%h count=%0d expected 0000 4", m_data[0], buf_count[0]);
    end
    m_ready = 1'b1;
    wait_cnt(0, 10, 200, "backpressure");
    check_seq(0, 10, 0, "backpressure_order");
  endtask

  task automatic test_flush();
    bit found = 1'b0;
    do_reset();
    for (int k = 0; k < 10; k++) push(0, 16'(100 + k));
    for (int k = 0; k < 50 && !found; k++) begin
      tick(1);
      if (buf_count[0] === 3'd3 && fifo_rd_en[0] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL flush_setup_timeout: got count=%0d expected 3 with a read in flight", buf_count[0]);
      return;
    end
    tick(1);
    flush = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en[0] !== 1'b0) begin
      failures++; $display("FAIL flush_cycle_read: got %b expected 0", fifo_rd_en[0]);
    end
    tick(1);
    flush = 1'b0;
    checks++;
    if (m_valid[0] !== 1'b0 || buf_count[0] !== 3'd0) begin
      failures++; $display("FAIL flush_clear: valid=%b count=%0d expected 0 0", m_valid[0], buf_count[0]);
    end
    m_ready = 1'b1;
    wait_cnt(0, 6, 200, "flush");
    check_seq(0, 6, 104, "flush_order");
    checks++;
    if (rd_word_cnt[0] !== 32'd6) begin
      failures++; $display("FAIL flush_count: got %0d expected 6", rd_word_cnt[0]);
    end
  endtask

  task automatic test_random();
    int pushed = 0;
    int k;
    do_reset();
    for (k = 0; k < 30000; k++) begin
      if (cnt_m[0] >= 1000 && cnt_m[1] >= 1000) break;
      m_ready = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        push(0, 16'(pushed));
        push(1, 16'(pushed));
        pushed++;
      end
      tick(1);
    end
    checks++;
    if (cnt_m[0] < 1000 || cnt_m[1] < 1000) begin
      failures++; $display("FAIL random_timeout: delivered %0d/%0d expected 1000/1000", cnt_m[0], cnt_m[1]);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_word_cnt[i] !== 32'd1000) begin
        failures++; $display("FAIL random_count dut%0d: got %0d expected 1000", i, rd_word_cnt[i]);
      end
      check_seq(i, 1000, 0, (i == 0) ? "random_order_dut0" : "random_order_dut1");
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
